// File: rtl/fifo_burst_sched_pkg.sv
// fifo_burst_sched_pkg
// Shared definitions for the FIFO read-side burst scheduler:
//   - state_t : scheduler state encoding (IDLE / REQ / READ)
//   - clog2   : constant-evaluable ceiling log2, used to size the burst
//               length field (BLEN_W = clog2(BURST_LEN+1))
package fifo_burst_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_READ = 2'd2
    } state_t;

    // Ceiling log2; clog2(1) = 0, clog2(33) = 6.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_burst_sched.sv
// fifo_burst_sched
// Read-side scheduler for a synchronous FIFO with a one-cycle registered
// read port. It watches the FIFO fill level, requests a downstream burst
// slot, and after the grant drains exactly one burst as a valid/last
// stream. An end-of-frame flush drains the residue as a short burst and
// then reports completion.
//
// Optional build macro: FIFO_BURST_SCHED_STATS_EN
//   defined   -> o_stat_bursts / o_stat_short are live 16-bit counters
//   undefined -> both ports are tied to zero, no counters are built
//
// Ports:
//   i_clk, i_rstn      clock, asynchronous active-low reset
//   i_fifo_fill        FIFO fill count (ADDR_WIDTH+1 bits)
//   o_fifo_rd          FIFO read strobe
//   i_fifo_data        FIFO read data, valid the cycle after o_fifo_rd
//   i_flush            end-of-frame drain request
//   o_flush_done       one-cycle pulse once a flush has fully drained
//   o_burst_req        burst request level, held until i_burst_gnt
//   o_burst_len        word count of the requested burst
//   i_burst_gnt        one-cycle grant
//   o_valid/o_data     output word stream (no backpressure)
//   o_last             final word of the burst
//   o_proto_err        sticky: grant seen while not requesting
//   o_stat_bursts      bursts completed
//   o_stat_short       short (flush) bursts completed
module fifo_burst_sched
    import fifo_burst_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 9,
    parameter int BURST_LEN  = 32,
    localparam int BLEN_W    = clog2(BURST_LEN + 1),
    localparam int FILL_W    = ADDR_WIDTH + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [FILL_W-1:0]     i_fifo_fill,
    output logic                  o_fifo_rd,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    input  logic                  i_flush,
    output logic                  o_flush_done,
    output logic                  o_burst_req,
    output logic [BLEN_W-1:0]     o_burst_len,
    input  logic                  i_burst_gnt,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic                  o_proto_err,
    output logic [15:0]           o_stat_bursts,
    output logic [15:0]           o_stat_short
);

    localparam logic [FILL_W-1:0] BURST_LEN_FILL = FILL_W'(BURST_LEN);
    localparam logic [BLEN_W-1:0] BURST_LEN_B    = BLEN_W'(BURST_LEN);
    localparam logic [BLEN_W-1:0] ONE_B          = BLEN_W'(1);

    state_t              state_reg, state_next;
    logic [BLEN_W-1:0]   len_reg, len_next;
    logic [BLEN_W-1:0]   beat_reg, beat_next;
    logic                flush_pend_reg, flush_pend_next;
    logic                flush_q_reg;
    logic                valid_reg;
    logic                last_reg;
    logic                proto_err_reg;

    logic                fifo_rd;
    logic                flush_done;
    logic                flush_req;
    logic                final_beat;

    // A flush is a request event, not a level: holding i_flush high for
    // several cycles must still produce exactly one drain and one done pulse.
    assign flush_req  = i_flush & ~flush_q_reg;
    assign final_beat = (state_reg == ST_READ) && (beat_reg == ONE_B);

    always_comb begin
        state_next      = state_reg;
        len_next        = len_reg;
        beat_next       = beat_reg;
        flush_pend_next = flush_pend_reg;
        fifo_rd         = 1'b0;
        flush_done      = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                if (i_fifo_fill >= BURST_LEN_FILL) begin
                    // Full bursts win over a pending flush.
                    len_next   = BURST_LEN_B;
                    state_next = ST_REQ;
                end else if (flush_pend_reg && (i_fifo_fill != '0)) begin
                    // fill < BURST_LEN here, so it fits the length field.
                    len_next   = i_fifo_fill[BLEN_W-1:0];
                    state_next = ST_REQ;
                end else if (flush_pend_reg && !valid_reg) begin
                    // Fill is zero; wait for the last word to leave the
                    // output stage before declaring the flush complete.
                    flush_done      = 1'b1;
                    flush_pend_next = 1'b0;
                end
            end
            ST_REQ: begin
                if (i_burst_gnt) begin
                    beat_next  = len_reg;
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                fifo_rd   = 1'b1;
                beat_next = beat_reg - ONE_B;
                if (beat_reg == ONE_B) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (flush_req) begin
            flush_pend_next = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg      <= ST_IDLE;
            len_reg        <= '0;
            beat_reg       <= '0;
            flush_pend_reg <= 1'b0;
            flush_q_reg    <= 1'b0;
            valid_reg      <= 1'b0;
            last_reg       <= 1'b0;
            proto_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            len_reg        <= len_next;
            beat_reg       <= beat_next;
            flush_pend_reg <= flush_pend_next;
            flush_q_reg    <= i_flush;
            // One-stage pipe matching the FIFO's registered read latency.
            valid_reg      <= fifo_rd;
            last_reg       <= final_beat;
            if (i_burst_gnt && (state_reg != ST_REQ)) begin
                proto_err_reg <= 1'b1;
            end
        end
    end

    assign o_fifo_rd    = fifo_rd;
    assign o_flush_done = flush_done;
    assign o_burst_req  = (state_reg == ST_REQ);
    assign o_burst_len  = (state_reg == ST_REQ) ? len_reg : '0;
    assign o_valid      = valid_reg;
    // FIFO read data arrives the cycle after the strobe, aligned with
    // valid_reg; gate it so idle cycles show zero.
    assign o_data       = valid_reg ? i_fifo_data : '0;
    assign o_last       = last_reg;
    assign o_proto_err  = proto_err_reg;

`ifdef FIFO_BURST_SCHED_STATS_EN
    logic [15:0] stat_bursts_reg;
    logic [15:0] stat_short_reg;

    // While o_last is high, len_reg still holds the finishing burst's
    // length: a new length can only be latched on this same edge.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            stat_bursts_reg <= '0;
            stat_short_reg  <= '0;
        end else if (last_reg) begin
            stat_bursts_reg <= stat_bursts_reg + 16'd1;
            if (len_reg < BURST_LEN_B) begin
                stat_short_reg <= stat_short_reg + 16'd1;
            end
        end
    end

    assign o_stat_bursts = stat_bursts_reg;
    assign o_stat_short  = stat_short_reg;
`else
    assign o_stat_bursts = '0;
    assign o_stat_short  = '0;
`endif

endmodule

// File: tb/tb_fifo_burst_sched.sv
module tb_fifo_burst_sched;

    localparam int DW     = 12;
    localparam int AW     = 9;
    localparam int BL     = 32;
    localparam int BLEN_W = 6;
    localparam int FILL_W = AW + 1;
    localparam int DEPTH  = 1 << AW;

    logic              clk = 1'b0;
    logic              rstn;
    logic [FILL_W-1:0] fifo_fill = '0;
    logic              fifo_rd;
    logic [DW-1:0]     fifo_dout = '0;
    logic              flush = 1'b0;
    logic              flush_done;
    logic              burst_req;
    logic [BLEN_W-1:0] burst_len;
    logic              burst_gnt;
    logic              proto_gnt = 1'b0;
    logic              resp_gnt = 1'b0;
    logic              valid;
    logic [DW-1:0]     data;
    logic              last;
    logic              proto_err;
    logic [15:0]       stat_bursts;
    logic [15:0]       stat_short;

    assign burst_gnt = proto_gnt | resp_gnt;

    always #5 clk = ~clk;

    fifo_burst_sched #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .BURST_LEN (BL)
    ) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_fifo_fill  (fifo_fill),
        .o_fifo_rd    (fifo_rd),
        .i_fifo_data  (fifo_dout),
        .i_flush      (flush),
        .o_flush_done (flush_done),
        .o_burst_req  (burst_req),
        .o_burst_len  (burst_len),
        .i_burst_gnt  (burst_gnt),
        .o_valid      (valid),
        .o_data       (data),
        .o_last       (last),
        .o_proto_err  (proto_err),
        .o_stat_bursts(stat_bursts),
        .o_stat_short (stat_short)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model / scoreboard ----------------
    // Words leave in write order. Every BL accumulated words form one full
    // burst; a flush turns whatever remains into one short burst.
    logic [DW-1:0] exp_data[$];
    bit            exp_last[$];
    int            exp_len[$];
    int            pending   = 0;
    logic [15:0]   exp_bursts = '0;
    logic [15:0]   exp_short  = '0;
    int            exp_done  = 0;
    int            done_cnt  = 0;
    int            done_cyc  = -1;
    int            last_cyc  = -1;
    int            gnt_cyc   = 0;
    bit            lat_watch = 0;
    int            gnt_delay = 0;

    task automatic plan_burst(input int len);
        for (int i = 0; i < len; i++) exp_last.push_back(i == len - 1);
        exp_len.push_back(len);
        exp_bursts = exp_bursts + 16'd1;
        if (len < BL) exp_short = exp_short + 16'd1;
    endtask

    // ---------------- behavioural FIFO with registered read ----------------
    logic            wr_en = 1'b0;
    logic [DW-1:0]   wr_data = '0;
    logic [DW-1:0]   fq[$];

    always @(posedge clk) begin
        if (!rstn) begin
            fq.delete();
            fifo_fill <= '0;
            fifo_dout <= '0;
        end else begin
            if (fifo_rd) begin
                check("fifo_underflow", fq.size() == 0, 0);
                if (fq.size() != 0) fifo_dout <= fq.pop_front();
            end
            if (wr_en) begin
                check("fifo_overflow", fq.size() >= DEPTH, 0);
                if (fq.size() < DEPTH) fq.push_back(wr_data);
            end
            fifo_fill <= FILL_W'(fq.size());
        end
    end

    // ---------------- monitor ----------------
    logic [DW-1:0] m_data;
    bit            m_last;
    initial begin
        forever begin
            @(negedge clk);
            if (valid) begin
                check("valid_has_expectation", (exp_data.size() != 0) && (exp_last.size() != 0), 1);
                if (exp_data.size() != 0 && exp_last.size() != 0) begin
                    m_data = exp_data.pop_front();
                    m_last = exp_last.pop_front();
                    check("out_data", data, m_data);
                    check("out_last", last, m_last);
                end
                if (lat_watch) begin
                    check("grant_to_valid_latency", cyc - gnt_cyc, 2);
                    lat_watch = 0;
                end
                if (last) last_cyc = cyc;
            end else begin
                check("last_without_valid", last, 0);
            end
            if (flush_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // ---------------- downstream grant responder ----------------
    logic [BLEN_W-1:0] resp_len;
    initial begin
        forever begin
            @(negedge clk);
            if (burst_req && rstn) begin
                resp_len = burst_len;
                check("req_has_expectation", exp_len.size() != 0, 1);
                if (exp_len.size() != 0) check("burst_len", burst_len, exp_len.pop_front());
                for (int i = 0; i < gnt_delay; i++) begin
                    @(negedge clk);
                    check("req_held_stable", {burst_req, burst_len}, {1'b1, resp_len});
                end
                resp_gnt  = 1'b1;
                gnt_cyc   = cyc;
                lat_watch = 1;
                @(negedge clk);
                resp_gnt  = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic write_words(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = DW'($urandom);
            exp_data.push_back(wr_data);
            pending++;
            if (pending == BL) begin
                plan_burst(BL);
                pending = 0;
            end
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic flush_pulse();
        @(negedge clk);
        flush = 1'b1;
        if (pending > 0) plan_burst(pending);
        pending = 0;
        exp_done++;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic wait_drain(input int max);
        int n;
        n = 0;
        while (exp_last.size() != 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        check("drain_within_budget", exp_last.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_done(input int max);
        int n;
        n = 0;
        while (done_cnt < exp_done && n < max) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("flush_done_count", done_cnt, exp_done);
    endtask

    task automatic wait_rd(input int max);
        int n;
        n = 0;
        while (!fifo_rd && n < max) begin
            @(negedge clk);
            n++;
        end
        check("read_seen", fifo_rd, 1);
    endtask

    task automatic check_stats(input string tag);
`ifdef FIFO_BURST_SCHED_STATS_EN
        check({tag, "_stat_bursts"}, stat_bursts, exp_bursts);
        check({tag, "_stat_short"}, stat_short, exp_short);
`else
        check({tag, "_stat_bursts_tied"}, stat_bursts, 0);
        check({tag, "_stat_short_tied"}, stat_short, 0);
`endif
    endtask

    // ---------------- main sequence ----------------
    int fcyc;
    initial begin
        rstn = 1'b1;
        #2 rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_fifo_rd", fifo_rd, 0);
        check("reset_valid", valid, 0);
        check("reset_last", last, 0);
        check("reset_data", data, 0);
        check("reset_burst_req", burst_req, 0);
        check("reset_burst_len", burst_len, 0);
        check("reset_flush_done", flush_done, 0);
        check("reset_proto_err", proto_err, 0);
        check("reset_stat_bursts", stat_bursts, 0);
        check("reset_stat_short", stat_short, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // 40 words, grant held off 5 cycles: one full burst, 8 words left.
        gnt_delay = 5;
        write_words(40);
        wait_drain(300);
        repeat (10) @(negedge clk);
        check("s1_fill_residue", fifo_fill, 8);
        check("s1_no_new_request", burst_req, 0);
        check_stats("s1");
        $display("s1 full burst: fill=%0d checks=%0d errors=%0d", fifo_fill, checks, errors);

        // Flush the 8-word residue.
        gnt_delay = 1;
        flush_pulse();
        wait_drain(200);
        wait_done(50);
        check("s2_done_after_last", done_cyc, last_cyc + 1);
        check_stats("s2");
        $display("s2 short flush burst: done_cyc=%0d last_cyc=%0d", done_cyc, last_cyc);

        // Empty flush: done on the next cycle, no request.
        @(negedge clk);
        flush = 1'b1;
        fcyc = cyc;
        exp_done++;
        @(negedge clk);
        flush = 1'b0;
        repeat (4) @(negedge clk);
        check("s3_empty_done_latency", done_cyc, fcyc + 1);
        check("s3_empty_done_count", done_cnt, exp_done);
        // Held 3 cycles: still a single pulse.
        @(negedge clk);
        flush = 1'b1;
        exp_done++;
        repeat (3) @(negedge clk);
        flush = 1'b0;
        repeat (6) @(negedge clk);
        check("s3_held_flush_single_pulse", done_cnt, exp_done);
        $display("s3 empty flushes: done pulses=%0d", done_cnt);

        // 70 words, flush mid-burst: bursts 32, 32, 6.
        gnt_delay = 0;
        write_words(70);
        wait_rd(200);
        flush_pulse();
        wait_drain(400);
        wait_done(50);
        check("s4_done_after_final_last", done_cyc, last_cyc + 1);
        check_stats("s4");
        $display("s4 flush mid-burst: bursts=%0d short=%0d", exp_bursts, exp_short);

        // Continuous streaming with immediate grants.
        write_words(1000);
        flush_pulse();
        wait_drain(3000);
        wait_done(100);
        check("s6_fifo_empty", fifo_fill, 0);
        check_stats("s6");
        check("s6_no_proto_err", proto_err, 0);
        $display("s6 continuous: bursts=%0d short=%0d", exp_bursts, exp_short);

        // Grant outside REQ: sticky error, no reads.
        @(negedge clk);
        proto_gnt = 1'b1;
        @(negedge clk);
        proto_gnt = 1'b0;
        check("s5_proto_err_set", proto_err, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("s5_no_read_after_stray_grant", fifo_rd, 0);
        end
        check("s5_proto_err_sticky", proto_err, 1);

        // Reset in the middle of a READ.
        write_words(32);
        wait_rd(200);
        repeat (3) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("s5_async_fifo_rd", fifo_rd, 0);
        check("s5_async_valid", valid, 0);
        check("s5_async_last", last, 0);
        check("s5_async_proto_err", proto_err, 0);
        check("s5_async_burst_req", burst_req, 0);
        exp_data.delete();
        exp_last.delete();
        exp_len.delete();
        pending    = 0;
        lat_watch  = 0;
        exp_bursts = '0;
        exp_short  = '0;
        check_stats("s5_reset");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        check("s5_idle_after_reset", {burst_req, fifo_rd, valid}, 3'b000);
        $display("s5 proto error and mid-burst reset done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
